// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Word-addressed data memory for the MEM stage of a 5-stage pipeline.
// Each request is latched in the cycle it is presented. After LATENCY wait
// states the storage access takes place, and one DONE cycle follows. The
// pipeline is stalled through mem_busy until DONE.
//
// Parameters
//   DEPTH    number of 32-bit words stored (word index = data_address[31:2])
//   LATENCY  wait-state cycles between acceptance and the access (0..15)
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   MemRead       read request
//   MemWrite      write request
//   data_address  byte address of the access
//   data          write data
//   MemOut        registered read data, valid with mem_done and held after
//   mem_busy      stall to the pipeline (combinational)
//   mem_done      one-cycle completion strobe
//   mem_err       error flag for the completing access, valid with mem_done
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] data_address,
    input  logic [31:0] data,
    output logic [31:0] MemOut,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   lat_index;
    logic [31:0]     lat_data;
    logic            lat_read;
    logic            lat_write;
    logic            lat_err;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic [29:0]     in_index;
    logic            in_err;
    logic            access_now;
    logic [AW-1:0]   acc_index;
    logic [31:0]     acc_data;
    logic            acc_read;
    logic            acc_write;
    logic            acc_err;
    logic            mem_we;

    assign req      = MemRead | MemWrite;
    assign in_index = data_address[31:2];

    // The range check uses the full 30-bit word index; one extra bit lets
    // DEPTH = 2^30 be represented in the compare.
    assign in_err = (data_address[1:0] != 2'b00)
                  | ({1'b0, in_index} >= 31'(DEPTH))
                  | (MemRead & MemWrite);

    // With zero wait states the access happens on the accepting edge, so it
    // must use the live inputs; otherwise it uses the values latched earlier.
    assign access_now = ((state == ST_IDLE) && req && (LAT == 4'd0))
                      || ((state == ST_WAIT) && (cnt == 4'd1));

    always_comb begin
        acc_index = lat_index;
        acc_data  = lat_data;
        acc_read  = lat_read;
        acc_write = lat_write;
        acc_err   = lat_err;
        if (state == ST_IDLE) begin
            acc_index = in_index[AW-1:0];
            acc_data  = data;
            acc_read  = MemRead;
            acc_write = MemWrite;
            acc_err   = in_err;
        end
    end

    // rst_n gate keeps a zero-latency request from writing while reset is held.
    assign mem_we = access_now & acc_write & ~acc_err & rst_n;

    always_comb begin
        mem_busy = 1'b0;
        case (state)
            ST_IDLE: mem_busy = req;
            ST_WAIT: mem_busy = 1'b1;
            ST_DONE: mem_busy = 1'b0;
            default: mem_busy = 1'b0;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_index] <= acc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_index <= '0;
            lat_data  <= 32'd0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            MemOut    <= 32'd0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            // DONE is entered only on an access edge and lasts one cycle,
            // so the strobes simply follow the access.
            mem_done <= access_now;
            mem_err  <= access_now & acc_err;

            // An erroneous read (including a dual request) returns zero;
            // an erroneous write leaves MemOut alone.
            if (access_now && acc_read) begin
                if (acc_err) begin
                    MemOut <= 32'd0;
                end else begin
                    MemOut <= mem[acc_index];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_index <= in_index[AW-1:0];
                        lat_data  <= data;
                        lat_read  <= MemRead;
                        lat_write <= MemWrite;
                        lat_err   <= in_err;
                        cnt       <= LAT;
                        state     <= (LAT == 4'd0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // The request still presented here belongs to the
                    // access just completed, so it is ignored.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives two responders (LATENCY=2 and LATENCY=0, DEPTH=256) with directed
// transactions. Each transaction is turned into an expected per-cycle
// schedule of mem_busy / mem_done / mem_err / MemOut, derived from the
// access timing (busy for 1+LATENCY cycles, then one DONE cycle) and a word
// image of the storage. A single compare process checks both DUTs against
// that schedule on every falling edge. Literal checks pin key results.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NC = 512;

    logic        clk;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] out   [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    bit          sched_busy [2][NC];
    bit          sched_done [2][NC];
    bit          sched_err  [2][NC];
    logic [31:0] sched_out  [2][NC];
    logic [31:0] model_out  [2];
    logic [31:0] img [bit [30:0]];

    int busy_cycles [2];
    int done_pulses [2];

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .MemRead(rd[0]), .MemWrite(wr[0]),
        .data_address(addr[0]), .data(wdat[0]),
        .MemOut(out[0]), .mem_busy(busy[0]),
        .mem_done(done[0]), .mem_err(err[0])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .MemRead(rd[1]), .MemWrite(wr[1]),
        .data_address(addr[1]), .data(wdat[1]),
        .MemOut(out[1]), .mem_busy(busy[1]),
        .mem_done(done[1]), .mem_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Presents one transaction just after a rising edge, records what the
    // outputs must do, holds the request through DONE like a stalled MEM
    // stage, and returns just after the edge that ends DONE.
    task automatic applyStimulus(input int d, input bit r, input bit w,
                                 input logic [31:0] a, input logic [31:0] dat);
        int          lat;
        int          t0;
        bit [29:0]   idx;
        bit [30:0]   key;
        bit          e;
        logic [31:0] nv;
        lat = (d == 0) ? 2 : 0;
        t0  = cyc;
        idx = a[31:2];
        key = {d[0], idx};
        e   = (a[1:0] != 2'b00) || (idx >= 30'd256) || (r && w);
        nv  = model_out[d];
        if (e) begin
            if (r) nv = 32'd0;
        end else if (r) begin
            nv = img.exists(key) ? img[key] : 32'd0;
        end else begin
            img[key] = dat;
        end
        for (int k = 0; k <= lat; k++) sched_busy[d][t0 + k] = 1'b1;
        sched_done[d][t0 + lat + 1] = 1'b1;
        sched_err[d][t0 + lat + 1]  = e;
        sched_out[d][t0 + lat + 1]  = nv;
        rd[d]   = r;
        wr[d]   = w;
        addr[d] = a;
        wdat[d] = dat;
        repeat (lat + 2) @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy[d] === 1'b1) busy_cycles[d]++;
            if (done[d] === 1'b1) done_pulses[d]++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            for (int d = 0; d < 2; d++) begin
                if (sched_done[d][cyc]) model_out[d] = sched_out[d][cyc];
                checkOutput($sformatf("busy%0d@%0d", d, cyc), {31'd0, busy[d]},
                            {31'd0, sched_busy[d][cyc]});
                checkOutput($sformatf("done%0d@%0d", d, cyc), {31'd0, done[d]},
                            {31'd0, sched_done[d][cyc]});
                checkOutput($sformatf("err%0d@%0d", d, cyc), {31'd0, err[d]},
                            {31'd0, sched_done[d][cyc] & sched_err[d][cyc]});
                checkOutput($sformatf("out%0d@%0d", d, cyc), out[d], model_out[d]);
            end
        end
    end

    initial begin
        int b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0; wdat[d] = 32'd0;
            model_out[d] = 32'd0; busy_cycles[d] = 0; done_pulses[d] = 0;
            for (int i = 0; i < NC; i++) begin
                sched_busy[d][i] = 1'b0; sched_done[d][i] = 1'b0;
                sched_err[d][i] = 1'b0; sched_out[d][i] = 32'd0;
            end
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst_out%0d", d), out[d], 32'd0);
            checkOutput($sformatf("rst_busy%0d", d), {31'd0, busy[d]}, 32'd0);
            checkOutput($sformatf("rst_done%0d", d), {31'd0, done[d]}, 32'd0);
            checkOutput($sformatf("rst_err%0d", d), {31'd0, err[d]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // LATENCY=2: first write, then populate a few words
        b0 = busy_cycles[0];
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        checkOutput("wr10_busy_cycles", busy_cycles[0] - b0, 32'd3);
        checkOutput("wr10_out_unchanged", out[0], 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h0BADF00D);
        applyStimulus(0, 1'b0, 1'b1, 32'h14, 32'h55AA55AA);

        // Back-to-back reads, each held through DONE
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        checkOutput("rd10_out", out[0], 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0);
        checkOutput("rd14_out", out[0], 32'h55AA55AA);

        // Misaligned and out-of-range reads, then a good read
        applyStimulus(0, 1'b1, 1'b0, 32'h12, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0);
        checkOutput("rd400_out_zero", out[0], 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        checkOutput("rd10_again", out[0], 32'hDEADBEEF);

        // Dual request must not write
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);
        checkOutput("rd20_after_dual", out[0], 32'h12345678);

        // Misaligned write must not touch word 0x30, nor MemOut
        applyStimulus(0, 1'b0, 1'b1, 32'h31, 32'h77777777);
        checkOutput("badwr_out_held", out[0], 32'h12345678);
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
        checkOutput("rd30_out", out[0], 32'h0BADF00D);

        // Reset during the WAIT state of a write discards it
        chk_en = 1'b0;
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h30; wdat[0] = 32'hCAFEF00D;
        #1 checkOutput("rstwr_req_busy", {31'd0, busy[0]}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rstwr_wait_busy", {31'd0, busy[0]}, 32'd1);
        checkOutput("rstwr_wait_done", {31'd0, done[0]}, 32'd0);
        #2;
        rst_n = 1'b0;
        wr[0] = 1'b0;
        #1;
        checkOutput("midrst_out", out[0], 32'd0);
        checkOutput("midrst_done", {31'd0, done[0]}, 32'd0);
        checkOutput("midrst_err", {31'd0, err[0]}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy[0]}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = cyc; i < NC; i++) begin
                sched_busy[d][i] = 1'b0; sched_done[d][i] = 1'b0;
                sched_err[d][i] = 1'b0;
            end
        end
        model_out[0] = 32'd0;
        chk_en = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
        checkOutput("rd30_after_rst", out[0], 32'h0BADF00D);

        // LATENCY=0 instance
        b0 = busy_cycles[1];
        applyStimulus(1, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5);
        checkOutput("l0_wr_busy_cycles", busy_cycles[1] - b0, 32'd1);
        b0 = busy_cycles[1];
        applyStimulus(1, 1'b1, 1'b0, 32'h44, 32'h0);
        checkOutput("l0_rd_busy_cycles", busy_cycles[1] - b0, 32'd1);
        checkOutput("l0_rd44_out", out[1], 32'hA5A5A5A5);
        applyStimulus(1, 1'b1, 1'b0, 32'h400, 32'h0);
        checkOutput("l0_rd400_out", out[1], 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_pulses0", done_pulses[0], 32'd14);
        checkOutput("done_pulses1", done_pulses[1], 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
